kv_status_table: RTL

Key/status store for the DNS reflection filter, directly downstream of the Ethernet parser. It accepts one request per cycle on the `in_key`/`in_flag`/`in_valid` lookup bus and answers on `out_valid`/`out_flag` at a fixed latency of two cycles. It is a direct-mapped table of flow keys, each tagged with a 2-bit status (suspect / arrest / filtered). The parser drops packets whose reply carries the arrest status.

---
 rtl/kv_status_table_pkg.sv | 35 +++
 rtl/kv_status_ram.sv | 25 ++
 rtl/kv_status_table.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/kv_status_table_pkg.sv
// Shared definitions for the DNS reflection filter key/status table:
// status codes, lookup-bus flag layout and the index fold hash.
package kv_status_table_pkg;

    typedef logic [1:0] status_t;

    localparam status_t STATUS_NONE     = 2'b00;
    localparam status_t STATUS_SUSPECT  = 2'b01;
    localparam status_t STATUS_ARREST   = 2'b10;
    localparam status_t STATUS_FILTERED = 2'b11;

    localparam int unsigned FLAG_WE      = 0;
    localparam int unsigned FLAG_REQ_LSB = 1;
    localparam int unsigned FLAG_REQ_MSB = 2;

    localparam int unsigned HASH_KEY_MAX = 256;
    localparam int unsigned HASH_IDX_MAX = 16;

    // Bit i of the key lands in index bit (i mod idx_w); bits above the real
    // key width are zero, which gives the zero-padded final slice.
    function automatic logic [HASH_IDX_MAX-1:0] fold_hash(
        input logic [HASH_KEY_MAX-1:0] key,
        input int unsigned             idx_w
    );
        logic [HASH_IDX_MAX-1:0] h;
        logic [3:0]              b;
        h = '0;
        for (int unsigned i = 0; i < HASH_KEY_MAX; i++) begin
            b    = 4'(i % idx_w);
            h[b] = h[b] ^ key[i];
        end
        return h;
    endfunction

endpackage

// File: rtl/kv_status_ram.sv
// Simple dual-port table storage: one write port, one registered read port.
module kv_status_ram #(
    parameter int unsigned DATA_W = 99,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk156,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk156) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/kv_status_table.sv
// Direct-mapped flow key/status table with a two-cycle lookup/update pipeline
// and a background zeroing sweep after reset or on clear.
module kv_status_table
    import kv_status_table_pkg::*;
#(
    parameter int unsigned KEY_SIZE   = 96,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                clk156,
    input  logic                eth_rst,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    input  logic                in_valid,
    output logic                out_valid,
    output logic [3:0]          out_flag,
    input  logic                clear,
    output logic                busy,
    output logic [15:0]         evict_cnt
);

    localparam int unsigned ENTRY_W = KEY_SIZE + 3;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;

    logic                  s1_valid;
    logic [KEY_SIZE-1:0]   s1_key;
    logic [2:0]            s1_flag;
    logic [ADDR_WIDTH-1:0] s1_idx;

    logic                  fwd_valid;
    logic [ADDR_WIDTH-1:0] fwd_idx;
    logic [ENTRY_W-1:0]    fwd_entry;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic [ENTRY_W-1:0]    rd_data;
    logic [ENTRY_W-1:0]    cur_entry;
    logic                  cur_valid;
    logic [KEY_SIZE-1:0]   cur_key;
    status_t               cur_status;
    status_t               req_status;
    status_t               upd_status;
    logic                  hit;
    logic                  evict;
    logic                  upd_we;
    logic [3:0]            reply;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ENTRY_W-1:0]    wr_data;

    logic                  flag_rsvd_unused;

    assign flag_rsvd_unused = in_flag[3];
    assign busy             = (state != ST_RUN);

    always_comb begin
        req_idx = ADDR_WIDTH'(fold_hash(HASH_KEY_MAX'(in_key), ADDR_WIDTH));
    end

    // The RAM reads old data when the previous cycle wrote the same slot,
    // so the last write is replayed over the read data.
    always_comb begin
        cur_entry  = (fwd_valid && (fwd_idx == s1_idx)) ? fwd_entry : rd_data;
        cur_valid  = cur_entry[ENTRY_W-1];
        cur_key    = cur_entry[ENTRY_W-2:2];
        cur_status = cur_entry[1:0];
        hit        = cur_valid && (cur_key == s1_key);
        req_status = s1_flag[FLAG_REQ_MSB:FLAG_REQ_LSB];
        upd_we     = 1'b0;
        evict      = 1'b0;
        upd_status = hit ? cur_status : STATUS_NONE;
        if ((state == ST_RUN) && s1_valid && s1_flag[FLAG_WE]) begin
            case (req_status)
                STATUS_SUSPECT: begin
                    if (!hit) begin
                        upd_we     = 1'b1;
                        evict      = cur_valid;
                        upd_status = STATUS_SUSPECT;
                    end
                end
                STATUS_ARREST: begin
                    if (hit && (cur_status == STATUS_SUSPECT)) begin
                        upd_we     = 1'b1;
                        upd_status = STATUS_ARREST;
                    end
                end
                STATUS_FILTERED: begin
                    upd_we     = 1'b1;
                    evict      = cur_valid && !hit;
                    upd_status = STATUS_FILTERED;
                end
                default: ;
            endcase
        end
        reply = (state == ST_RUN) ? {evict, upd_status, hit} : 4'b0000;
    end

    always_comb begin
        if (state != ST_RUN) begin
            wr_en   = 1'b1;
            wr_addr = sweep_cnt;
            wr_data = '0;
        end else begin
            wr_en   = upd_we;
            wr_addr = s1_idx;
            wr_data = {1'b1, s1_key, upd_status};
        end
    end

    kv_status_ram #(
        .DATA_W (ENTRY_W),
        .ADDR_W (ADDR_WIDTH)
    ) u_ram (
        .clk156  (clk156),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (req_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
            s1_valid  <= 1'b0;
            s1_key    <= '0;
            s1_flag   <= '0;
            s1_idx    <= '0;
            fwd_valid <= 1'b0;
            fwd_idx   <= '0;
            fwd_entry <= '0;
            out_valid <= 1'b0;
            out_flag  <= '0;
            evict_cnt <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_key    <= in_key;
            s1_flag   <= in_flag[2:0];
            s1_idx    <= req_idx;
            fwd_valid <= wr_en;
            fwd_idx   <= wr_addr;
            fwd_entry <= wr_data;
            out_valid <= s1_valid;
            out_flag  <= s1_valid ? reply : 4'b0000;
            if (evict && (evict_cnt != '1)) begin
                evict_cnt <= evict_cnt + 16'd1;
            end
            case (state)
                ST_INIT, ST_SWEEP: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == '1) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clear) begin
                        state     <= ST_SWEEP;
                        sweep_cnt <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
